// File: rtl/lpc_record_buffer.sv
// lpc_record_buffer
// Captures completed LPC cycles from the decoder, queues them in a record
// FIFO and serialises each record as a byte stream for the UART transmitter.
// Overflowing captures are dropped and counted (sticky flag + saturating count).
// Build option: define LPC_RECORD_MARKER_EN to prefix every record with an
// 8'hA5 marker byte so the host can resynchronise on the stream.
module lpc_record_buffer #(
   parameter int DEPTH = 16
) (
   input  logic                     lpc_clock,
   input  logic                     reset,
   input  logic [3:0]               in_cyctype_dir,
   input  logic [31:0]              in_addr,
   input  logic [7:0]               in_data,
   input  logic                     in_clock_enable,
   output logic [7:0]               out_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [$clog2(DEPTH):0]   fifo_count,
   output logic                     overflow,
   output logic [7:0]               drop_count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
`ifdef LPC_RECORD_MARKER_EN
   localparam int REC_LEN = 7;
`else
   localparam int REC_LEN = 6;
`endif
   localparam logic [2:0] LAST_IDX = 3'(REC_LEN - 1);

   typedef enum logic {S_IDLE, S_SEND} state_e;

   logic [43:0]   mem_q [DEPTH];
   logic          en_q, en_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          overflow_q, overflow_d;
   logic [7:0]    drop_q, drop_d;
   state_e        state_q, state_d;
   logic [2:0]    idx_q, idx_d;
   logic [43:0]   rec_q, rec_d;

   logic          push_req, full, push, drop, pop;

   // Byte k of the payload: {0, cyctype_dir}, address MSB first, then data.
   function automatic logic [7:0] payload_byte(input logic [43:0] rec, input logic [2:0] k);
      case (k)
         3'd0:    payload_byte = {4'h0, rec[43:40]};
         3'd1:    payload_byte = rec[39:32];
         3'd2:    payload_byte = rec[31:24];
         3'd3:    payload_byte = rec[23:16];
         3'd4:    payload_byte = rec[15:8];
         3'd5:    payload_byte = rec[7:0];
         default: payload_byte = 8'h00;
      endcase
   endfunction

   // Capture edge detect and FIFO admission; fullness is judged before any same-cycle pop.
   always_comb begin
      push_req = in_clock_enable & ~en_q;
      full     = (count_q == CW'(DEPTH));
      push     = push_req & ~full;
      drop     = push_req & full;
      en_d     = in_clock_enable;
   end

   // Serialiser FSM: pop a record when idle, then hand out one byte per handshake.
   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
      state_d   = state_q;
      idx_d     = idx_q;
      rec_d     = rec_q;
      pop       = 1'b0;
      out_valid = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (count_q != '0) begin
               pop     = 1'b1;
               rec_d   = mem_q[rd_ptr_q];
               idx_d   = 3'd0;
               state_d = S_SEND;
            end
         end
         S_SEND: begin
            out_valid = 1'b1;
            if (out_ready) begin
               if (idx_q == LAST_IDX) state_d = S_IDLE;
               else                   idx_d   = idx_q + 3'd1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Pointer, occupancy and overflow bookkeeping.
   always_comb begin
      wr_ptr_d   = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d   = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
      count_d    = count_q;
      if (push && !pop)      count_d = count_q + CW'(1);
      else if (pop && !push) count_d = count_q - CW'(1);
      overflow_d = overflow_q | drop;
      drop_d     = (drop && drop_q != 8'hFF) ? drop_q + 8'd1 : drop_q;
   end

   // Current output byte; forced to zero outside SEND so it idles at its reset value.
   always_comb begin
      out_data = 8'h00;
      if (state_q == S_SEND) begin
`ifdef LPC_RECORD_MARKER_EN
         out_data = (idx_q == 3'd0) ? 8'hA5 : payload_byte(rec_q, idx_q - 3'd1);
`else
         out_data = payload_byte(rec_q, idx_q);
`endif
      end
   end

   // Control state registers with synchronous active-low reset.
   always_ff @(posedge lpc_clock) begin
      // NOTE: non-blocking assignments for all state so every flop sees pre-edge values.
      if (!reset) begin
         en_q       <= 1'b1;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
         drop_q     <= 8'h00;
         state_q    <= S_IDLE;
         idx_q      <= 3'd0;
         rec_q      <= '0;
      end else begin
         en_q       <= en_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
         drop_q     <= drop_d;
         state_q    <= state_d;
         idx_q      <= idx_d;
         rec_q      <= rec_d;
      end
   end

   // Record storage write port.
   always_ff @(posedge lpc_clock) begin
      // NOTE: storage is not reset; the pointers and count alone define which entries are valid.
      if (push) mem_q[wr_ptr_q] <= {in_cyctype_dir, in_addr, in_data};
   end

   assign fifo_count = count_q;
   assign overflow   = overflow_q;
   assign drop_count = drop_q;

endmodule

// File: tb/tb_lpc_record_buffer.sv
// Directed testbench for lpc_record_buffer: latency, backpressure, overflow,
// drop-count saturation, push-while-full-with-pop and reset mid-record.
module tb_lpc_record_buffer;

   localparam int DEPTH = 16;
`ifdef LPC_RECORD_MARKER_EN
   localparam int REC_LEN = 7;
`else
   localparam int REC_LEN = 6;
`endif

   logic                   lpc_clock = 1'b0;
   logic                   reset;
   logic [3:0]             in_cyctype_dir;
   logic [31:0]            in_addr;
   logic [7:0]             in_data;
   logic                   in_clock_enable;
   logic [7:0]             out_data;
   logic                   out_valid;
   logic                   out_ready;
   logic [$clog2(DEPTH):0] fifo_count;
   logic                   overflow;
   logic [7:0]             drop_count;

   int checks = 0;
   int errors = 0;
   logic [43:0] exp_q [$];

   lpc_record_buffer #(.DEPTH(DEPTH)) dut (
      .lpc_clock       (lpc_clock),
      .reset           (reset),
      .in_cyctype_dir  (in_cyctype_dir),
      .in_addr         (in_addr),
      .in_data         (in_data),
      .in_clock_enable (in_clock_enable),
      .out_data        (out_data),
      .out_valid       (out_valid),
      .out_ready       (out_ready),
      .fifo_count      (fifo_count),
      .overflow        (overflow),
      .drop_count      (drop_count)
   );

   always #5 lpc_clock = ~lpc_clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Expected serial byte i of a record.
   function automatic logic [7:0] exp_byte(input logic [43:0] r, input int i);
      int k;
      k = i;
`ifdef LPC_RECORD_MARKER_EN
      if (k == 0) return 8'hA5;
      k = k - 1;
`endif
      case (k)
         0:       return {4'h0, r[43:40]};
         1:       return r[39:32];
         2:       return r[31:24];
         3:       return r[23:16];
         4:       return r[15:8];
         5:       return r[7:0];
         default: return 8'hXX;
      endcase
   endfunction

   function automatic logic [43:0] mk_rec(input int k);
      return {4'(k), 32'hC0DE_0000 + 32'(k * 257), 8'(k * 3 + 1)};
   endfunction

   // One rising edge of in_clock_enable; returns at the negedge after the capture edge.
   task automatic capture(input logic [43:0] r);
      @(negedge lpc_clock);
      {in_cyctype_dir, in_addr, in_data} = r;
      in_clock_enable = 1'b1;
      @(negedge lpc_clock);
      in_clock_enable = 1'b0;
   endtask

   // Consume nbytes of record r starting at the current negedge; optionally toggle out_ready.
   // While out_valid & ~out_ready the byte must already equal the pending expected byte.
   // Returns at the negedge following the last accepted byte.
   task automatic recv_record(input logic [43:0] r, input bit toggle, input int nbytes,
                              input string tag);
      int b     = 0;
      int guard = 0;
      bit rdy   = 1'b1;
      while (b < nbytes && guard <= 100) begin
         out_ready = toggle ? rdy : 1'b1;
         if (out_valid) begin
            check($sformatf("%s byte%0d", tag, b), 32'(out_data), 32'(exp_byte(r, b)));
            if (out_ready) b++;
         end
         rdy = ~rdy;
         @(negedge lpc_clock);
         guard++;
      end
      if (b < nbytes) check($sformatf("%s timeout", tag), 32'(b), 32'(nbytes));
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, " out_valid"},  32'(out_valid),  32'(0));
      check({tag, " out_data"},   32'(out_data),   32'(0));
      check({tag, " fifo_count"}, 32'(fifo_count), 32'(0));
      check({tag, " overflow"},   32'(overflow),   32'(0));
      check({tag, " drop_count"}, 32'(drop_count), 32'(0));
   endtask

   initial begin
      logic [43:0] r1;
      logic [43:0] r6;
      r1 = {4'h2, 32'h0000_0080, 8'h5A};
      r6 = {4'hD, 32'hDEAD_BEEF, 8'h3C};

      reset           = 1'b0;
      in_clock_enable = 1'b0;
      in_cyctype_dir  = '0;
      in_addr         = '0;
      in_data         = '0;
      out_ready       = 1'b0;
      repeat (3) @(negedge lpc_clock);
      check_reset_values("reset");
      reset = 1'b1;
      @(negedge lpc_clock);

      // Single record: 2-cycle first-byte latency, then back-to-back bytes.
      {in_cyctype_dir, in_addr, in_data} = r1;
      in_clock_enable = 1'b1;
      out_ready       = 1'b1;
      @(negedge lpc_clock);
      in_clock_enable = 1'b0;
      check("lat count after push", 32'(fifo_count), 32'(1));
      check("lat valid after push", 32'(out_valid), 32'(0));
      @(negedge lpc_clock);
      check("lat valid after pop", 32'(out_valid), 32'(1));
      check("lat count after pop", 32'(fifo_count), 32'(0));
      recv_record(r1, 1'b0, REC_LEN, "single");
      check("idle gap valid", 32'(out_valid), 32'(0));

      // Backpressure: out_ready alternating.
      capture(r1);
      recv_record(r1, 1'b1, REC_LEN, "bp");

      // Overflow: serialiser holds the first record, FIFO holds the next 16.
      out_ready = 1'b0;
      for (int k = 0; k < 17; k++) begin
         capture(mk_rec(k));
         exp_q.push_back(mk_rec(k));
      end
      check("full count", 32'(fifo_count), 32'(16));
      check("full overflow", 32'(overflow), 32'(0));
      check("full drop_count", 32'(drop_count), 32'(0));
      for (int k = 17; k < 21; k++) capture(mk_rec(k));
      check("ovf count", 32'(fifo_count), 32'(16));
      check("ovf overflow", 32'(overflow), 32'(1));
      check("ovf drop_count", 32'(drop_count), 32'(4));
      while (exp_q.size() != 0) begin
         recv_record(exp_q.pop_front(), 1'b0, REC_LEN, "drain");
      end
      check("drained count", 32'(fifo_count), 32'(0));
      check("drained valid", 32'(out_valid), 32'(0));

      // Push on the same edge as a pop while full: dropped, count 16 -> 15.
      out_ready = 1'b0;
      for (int k = 0; k < 17; k++) capture(mk_rec(k + 40));
      check("pp full count", 32'(fifo_count), 32'(16));
      recv_record(mk_rec(40), 1'b0, REC_LEN, "pp head");
      out_ready = 1'b0;
      {in_cyctype_dir, in_addr, in_data} = mk_rec(99);
      in_clock_enable = 1'b1;
      @(negedge lpc_clock);
      in_clock_enable = 1'b0;
      check("pp count", 32'(fifo_count), 32'(15));
      check("pp drop_count", 32'(drop_count), 32'(5));
      check("pp overflow", 32'(overflow), 32'(1));
      check("pp valid", 32'(out_valid), 32'(1));
      check("pp next head", 32'(out_data), 32'(exp_byte(mk_rec(41), 0)));

      // Saturation of drop_count.
      capture(mk_rec(60));
      check("sat full count", 32'(fifo_count), 32'(16));
      for (int i = 0; i < 249; i++) capture(mk_rec(i));
      check("sat 254", 32'(drop_count), 32'(254));
      for (int i = 0; i < 51; i++) capture(mk_rec(i));
      check("sat 255", 32'(drop_count), 32'(255));
      check("sat overflow", 32'(overflow), 32'(1));
      check("sat count", 32'(fifo_count), 32'(16));

      // Reset from a full buffer clears everything including the sticky flags.
      reset = 1'b0;
      @(negedge lpc_clock);
      check_reset_values("full reset");
      reset = 1'b1;

      // Reset mid-record with in_clock_enable held high across release.
      out_ready = 1'b1;
      capture(r6);
      recv_record(r6, 1'b0, 3, "partial");
      check("partial still valid", 32'(out_valid), 32'(1));
      check("partial byte3", 32'(out_data), 32'(exp_byte(r6, 3)));
      reset           = 1'b0;
      in_clock_enable = 1'b1;
      @(negedge lpc_clock);
      check_reset_values("mid reset");
      reset = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge lpc_clock);
         check($sformatf("post-reset valid %0d", i), 32'(out_valid), 32'(0));
         check($sformatf("post-reset count %0d", i), 32'(fifo_count), 32'(0));
      end
      in_clock_enable = 1'b0;
      repeat (3) @(negedge lpc_clock);
      check("enable low valid", 32'(out_valid), 32'(0));
      check("enable low count", 32'(fifo_count), 32'(0));
      check("enable low data", 32'(out_data), 32'(0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
